vga_fb_wr_arbiter: RTL

- Shares the single framebuffer write port of the VGA core between N_REQ requesters, e.g. test-pattern generator, sprite/overlay engine and host/UART writer.
- The port consists of addr_x, addr_y, color and we.
- Arbitration is round-robin with a bounded burst per grant.
- A pause input freezes all grants, e.g. while the pixel clock is being re-locked for a resolution change. Output sits directly on vga_top's write-port inputs.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_rr_picker.sv | 31 +++
 rtl/vga_fb_wr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA framebuffer write-port arbiter.
// The optional bounds check in vga_fb_wr_arbiter is controlled by VGA_FB_ARB_BOUNDS_CHECK_EN.
package vga_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} vga_arb_state_e;

  localparam int VGA_FB_ADDR_W  = 11;
  localparam int VGA_FB_COLOR_W = 2;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int vga_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_rr_picker.sv
// Combinational round-robin picker: first set bit of i_valid scanning from i_ptr upward, wrapping.
// Reusable by any arbiter that keeps its own rotating pointer.
module vga_rr_picker
  import vga_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_found,
  output logic [PTR_W-1:0] o_idx
);

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    int c;
    c       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(i_ptr) + k;
      if (c >= N) c = c - N;
      if (i_valid[c[PTR_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/vga_fb_wr_arbiter.sv
// Round-robin, burst-limited arbiter for the single VGA framebuffer write port.
// Define VGA_FB_ARB_BOUNDS_CHECK_EN to drop out-of-range beats and raise the sticky oob_o flag.
module vga_fb_wr_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = VGA_FB_ADDR_W,
  parameter int COLOR_W   = VGA_FB_COLOR_W,
  parameter int MAX_BURST = 16,
  parameter int H_MAX     = 1280,
  parameter int V_MAX     = 1024,
  localparam int ID_W     = vga_id_w(N_REQ)
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       pause_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_x_i,
  input  logic [N_REQ*ADDR_W-1:0]    req_y_i,
  input  logic [N_REQ*COLOR_W-1:0]   req_color_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       we_o,
  output logic [ADDR_W-1:0]          addr_x_o,
  output logic [ADDR_W-1:0]          addr_y_o,
  output logic [COLOR_W-1:0]         color_o,
  output logic [ID_W-1:0]            grant_id_o,
  output logic                       busy_o,
  output logic                       oob_o
);

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  // Handshake: a beat moves on a cycle where req_valid_i[i] && req_ready_o[i];
  // ready is only ever raised for the owner, and a requester holds valid and
  // payload stable until that beat is accepted.
  vga_arb_state_e      r_state, w_state_nxt;
  logic [ID_W-1:0]     r_owner, w_owner_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_found;
  logic                w_release;
  logic [N_REQ-1:0]    w_ready;
  logic                w_xfer;
  logic                w_oob_raw;
  logic                w_oob;
  logic [ADDR_W-1:0]   w_sel_x, w_sel_y;
  logic [COLOR_W-1:0]  w_sel_color;
  logic                r_we;
  logic [ADDR_W-1:0]   r_x, r_y;
  logic [COLOR_W-1:0]  r_color;
  logic                r_oob;

  vga_rr_picker #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_picker (
    .i_valid (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_ready     = '0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == ID_W'(i)) begin
        w_ready[i]  = (r_state == ARB_GRANT) && !pause_i;
        w_sel_x     = req_x_i[i*ADDR_W +: ADDR_W];
        w_sel_y     = req_y_i[i*ADDR_W +: ADDR_W];
        w_sel_color = req_color_i[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign w_xfer    = |(w_ready & req_valid_i);
  assign w_oob_raw = (32'(w_sel_x) >= H_MAX) || (32'(w_sel_y) >= V_MAX);

`ifdef VGA_FB_ARB_BOUNDS_CHECK_EN
  assign w_oob = w_oob_raw;
`else
  logic w_unused_oob;
  assign w_unused_oob = w_oob_raw;
  assign w_oob        = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_release      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (!pause_i && w_pick_found) begin
          w_state_nxt    = ARB_GRANT;
          w_owner_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        // A paused grant is frozen outright, even if the owner has gone idle.
        if (!pause_i) begin
          if (!w_xfer || (r_beat_cnt == LAST_BEAT)) w_release = 1'b1;
          else w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
    if (w_release) begin
      w_state_nxt    = ARB_IDLE;
      w_rr_ptr_nxt   = (r_owner == LAST_ID) ? '0 : r_owner + ID_W'(1);
      w_beat_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_we       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_color    <= '0;
      r_oob      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_we       <= w_xfer && !w_oob;
      if (w_xfer && !w_oob) begin
        r_x     <= w_sel_x;
        r_y     <= w_sel_y;
        r_color <= w_sel_color;
      end
      if (w_xfer && w_oob) r_oob <= 1'b1;
    end
  end

  assign req_ready_o = w_ready;
  assign we_o        = r_we;
  assign addr_x_o    = r_x;
  assign addr_y_o    = r_y;
  assign color_o     = r_color;
  assign grant_id_o  = r_owner;
  assign busy_o      = (r_state == ARB_GRANT);
  assign oob_o       = r_oob;

endmodule
